// File: rtl/au_muldiv_sequencer_if.sv
// Request/response and arithmetic-unit drive bundle for the mul/div sequencer.
// The slave modport is the sequencer's view; master is the parent's view.
interface au_muldiv_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rem;
  logic             err;
  logic [WIDTH-1:0] au_x;
  logic [WIDTH-1:0] au_y;
  logic             au_op1;
  logic             au_op0;
  logic [WIDTH-1:0] au_out;

  modport slave (
    input  start, div, a, b, au_out,
    output busy, done, result, rem, err, au_x, au_y, au_op1, au_op0
  );

  modport master (
    output start, div, a, b, au_out,
    input  busy, done, result, rem, err, au_x, au_y, au_op1, au_op0
  );
endinterface

// File: rtl/au_muldiv_sequencer.sv
// Sequences unsigned shift-add multiply and restoring divide over an external
// combinational add/sub unit, one iteration per clock, WIDTH iterations per op.
module au_muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  au_muldiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             div_reg, div_next;
  // Shared datapath: acc/r, mcand/q and mplier/d reuse the same registers.
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             err_reg, err_next;

  logic [WIDTH:0]   s;
  logic             sub_ok;
  logic [WIDTH-1:0] acc_iter, mcand_iter;
  logic [WIDTH-1:0] au_x_c, au_y_c;
  logic             au_op1_c, au_op0_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      div_reg    <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      result_reg <= '0;
      rem_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      result_reg <= result_next;
      rem_reg    <= rem_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    result_next = result_reg;
    rem_next    = rem_reg;
    err_next    = err_reg;
    au_x_c      = '0;
    au_y_c      = '0;
    au_op1_c    = 1'b0;
    au_op0_c    = 1'b0;

    // The unit reports no borrow, so the trial-subtract decision is made here
    // from the 17-bit partial remainder.
    s      = {acc_reg, mcand_reg[WIDTH-1]};
    sub_ok = s[WIDTH] || (s[WIDTH-1:0] >= mplier_reg);

    if (div_reg) begin
      acc_iter   = sub_ok ? bus.au_out : s[WIDTH-1:0];
      mcand_iter = {mcand_reg[WIDTH-2:0], sub_ok};
    end else begin
      acc_iter   = mplier_reg[0] ? bus.au_out : acc_reg;
      mcand_iter = mcand_reg << 1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          div_next = bus.div;
          cnt_next = '0;
          err_next = 1'b0;
          if (bus.div && (bus.b == '0)) begin
            result_next = '1;
            rem_next    = bus.a;
            err_next    = 1'b1;
            state_next  = DONE;
          end else begin
            acc_next    = '0;
            mcand_next  = bus.a;
            mplier_next = bus.b;
            state_next  = RUN;
          end
        end
      end
      RUN: begin
        if (div_reg) begin
          au_x_c   = s[WIDTH-1:0];
          au_y_c   = mplier_reg;
          au_op1_c = 1'b1;
        end else begin
          au_x_c      = acc_reg;
          au_y_c      = mcand_reg;
          mplier_next = mplier_reg >> 1;
        end
        acc_next   = acc_iter;
        mcand_next = mcand_iter;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          result_next = div_reg ? mcand_iter : acc_iter;
          rem_next    = div_reg ? acc_iter : '0;
          state_next  = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
  assign bus.rem    = rem_reg;
  assign bus.err    = err_reg;
  assign bus.au_x   = au_x_c;
  assign bus.au_y   = au_y_c;
  assign bus.au_op1 = au_op1_c;
  assign bus.au_op0 = au_op0_c;

endmodule

// File: tb/tb_au_muldiv_sequencer.sv
// Directed bench for au_muldiv_sequencer: vector table of mul/div cases plus
// hand sequences for busy-start, mid-run reset and back-to-back starts.
module tb_au_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  au_muldiv_sequencer_if #(.WIDTH(16)) bus ();

  au_muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of the parent's combinational arithmetic unit.
  always_comb begin
    case ({bus.au_op1, bus.au_op0})
      2'b00:   bus.au_out = bus.au_x + bus.au_y;
      2'b01:   bus.au_out = bus.au_x + 16'd1;
      2'b10:   bus.au_out = bus.au_x - bus.au_y;
      default: bus.au_out = bus.au_x - 16'd1;
    endcase
  end

  typedef struct {
    logic        div;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic d, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div   = d;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!bus.done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done after %0d cycles", k);
    end
  endtask

  initial begin
    int k;
    int seen;

    vecs[0] = '{1'b0, 16'd300,   16'd7,     16'h0834, 16'h0000, 1'b0, 16};
    vecs[1] = '{1'b0, 16'h1234,  16'h0100,  16'h3400, 16'h0000, 1'b0, 16};
    vecs[2] = '{1'b0, 16'hFFFF,  16'hFFFF,  16'h0001, 16'h0000, 1'b0, 16};
    vecs[3] = '{1'b1, 16'd1000,  16'd7,     16'd142,  16'd6,    1'b0, 16};
    vecs[4] = '{1'b1, 16'd5,     16'd9,     16'd0,    16'd5,    1'b0, 16};
    vecs[5] = '{1'b1, 16'hFFFF,  16'h8001,  16'h0001, 16'h7FFE, 1'b0, 16};
    vecs[6] = '{1'b1, 16'hFFFF,  16'h0001,  16'hFFFF, 16'h0000, 1'b0, 16};
    vecs[7] = '{1'b1, 16'h1234,  16'h0000,  16'hFFFF, 16'h1234, 1'b1, 0};
    vecs[8] = '{1'b1, 16'd1000,  16'd7,     16'd142,  16'd6,    1'b0, 16};
    vecs[9] = '{1'b0, 16'h0000,  16'hABCD,  16'h0000, 16'h0000, 1'b0, 16};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.div   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   bus.busy,   0);
    check("rst_done",   bus.done,   0);
    check("rst_result", bus.result, 0);
    check("rst_rem",    bus.rem,    0);
    check("rst_err",    bus.err,    0);
    check("rst_au",     {bus.au_x, bus.au_y, bus.au_op1, bus.au_op0}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].div, vecs[i].a, vecs[i].b);
      if (vecs[i].lat != 0)
        check($sformatf("v%0d_op", i), {bus.au_op1, bus.au_op0}, {vecs[i].div, 1'b0});
      wait_done(k);
      check($sformatf("v%0d_lat", i), k, vecs[i].lat);
      check($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      check($sformatf("v%0d_rem", i), bus.rem, vecs[i].rem);
      check($sformatf("v%0d_err", i), bus.err, vecs[i].err);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle", i), {bus.busy, bus.done}, 0);
      check($sformatf("v%0d_hold", i), bus.result, vecs[i].res);
      $display("op %0d: div=%0d a=0x%04h b=0x%04h -> result=0x%04h rem=0x%04h err=%0d lat=%0d",
               i, vecs[i].div, vecs[i].a, vecs[i].b, bus.result, bus.rem, bus.err, k);
    end

    // Start pulses while RUN and while DONE must be ignored.
    accept(1'b0, 16'd300, 16'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.div = 1'b1; bus.a = 16'd1; bus.b = 16'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("run_start_ignored", {bus.busy, bus.done}, 2'b10);
    wait_done(k);
    check("run_start_lat", k, 12);
    check("run_start_result", bus.result, 16'h0834);
    bus.start = 1'b1; bus.div = 1'b0; bus.a = 16'd9; bus.b = 16'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_start_ignored", bus.busy, 0);
    check("done_start_result", bus.result, 16'h0834);
    $display("busy-start: result=0x%04h busy=%0d", bus.result, bus.busy);

    // Reset after 8 iterations: no partial result, no done pulse.
    accept(1'b1, 16'd1000, 16'd7);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_state", {bus.busy, bus.done}, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_au", {bus.au_x, bus.au_y, bus.au_op1, bus.au_op0}, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    check("midrst_no_done", seen, 0);
    $display("mid-run reset: busy=%0d result=0x%04h done_pulses=%0d", bus.busy, bus.result, seen);

    // Start held high: next op accepted in the first IDLE cycle after DONE.
    @(negedge clk);
    bus.start = 1'b1; bus.div = 1'b0; bus.a = 16'd3; bus.b = 16'd5;
    @(posedge clk);
    #1;
    bus.a = 16'd4;
    wait_done(k);
    check("b2b_first_lat", k, 16);
    check("b2b_first_result", bus.result, 16'd15);
    @(posedge clk);
    #1;
    check("b2b_idle_gap", bus.busy, 0);
    @(posedge clk);
    #1;
    check("b2b_reaccept", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(k);
    check("b2b_second_lat", k, 16);
    check("b2b_second_result", bus.result, 16'd20);
    $display("back-to-back: second result=%0d lat=%0d", bus.result, k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/au_muldiv_sequencer.md
Name: au_muldiv_sequencer

Overview:
- Multi-cycle controller that runs unsigned 16x16 multiply (low 16 bits) and unsigned 16/16 divide on the team's shared 16-bit arithmetic unit.
- The arithmetic unit is an external, purely combinational block in the parent. It takes X, Y and op1/op0, where 00 = X+Y, 01 = X+1, 10 = X-Y, 11 = X-1.
- This block drives that unit's operands and op code one iteration per cycle, sequences 16 iterations, and returns the result with a done pulse.

Parameters:
- WIDTH, 16, operand and result width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- div  in  1  0 = multiply, 1 = divide; sampled with start.
- a  in  16  multiplicand or dividend; sampled with start.
- b  in  16  multiplier or divisor; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result, rem and err are valid in that cycle.
- result  out  16  product low 16 bits, or quotient.
- rem  out  16  remainder for divide; 0 for multiply.
- err  out  1  divide-by-zero flag for the last operation.
- au_x  out  16  arithmetic unit X operand.
- au_y  out  16  arithmetic unit Y operand.
- au_op1  out  1  arithmetic unit op1.
- au_op0  out  1  arithmetic unit op0.
- au_out  in  16  arithmetic unit result; combinational from au_x, au_y and the op pins.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state becomes IDLE; all internal registers clear.
  - busy, done, result, rem and err become 0.
  - Idle drive becomes au_x=0, au_y=0, op=00.
  - No partial result is ever reported.
- IDLE:
  - start=1 at edge E0 captures a, b and div, clears the counter and err, and moves to RUN.
  - Exception: div=1 and b=0 goes straight to DONE with result=16'hFFFF, rem=a, err=1.
  - start=0: remain in IDLE; outputs hold their last values.
- start while busy (RUN or DONE) is ignored, not queued.
- Multiply, one iteration per edge in RUN:
  - Registers: acc (init 0), mcand (init a), mplier (init b).
  - Drive au_x=acc, au_y=mcand, op=00.
  - If mplier[0]=1, acc takes au_out; otherwise acc holds.
  - Then mcand shifts left 1 (zero fill, MSB lost) and mplier shifts right 1.
  - Overflow wraps mod 2^16 with no flag.
- Divide, restoring, one iteration per edge in RUN:
  - Registers: r (init 0), q (init a), d = b.
  - Each cycle form the 17-bit value s = {r, q[15]}.
  - Drive au_x = s[15:0], au_y=d, op=10 (subtract).
  - Subtract succeeds if s[16]=1 or s[15:0] >= d, compared locally; the arithmetic unit gives no borrow.
  - On success: r takes au_out, q becomes {q[14:0], 1}.
  - Otherwise: r becomes s[15:0], q becomes {q[14:0], 0}.
  - When s[16]=1, au_out is the correct 16-bit remainder by modular wrap.
- RUN ends after exactly 16 iteration edges (E1 through E16), then moves to DONE.
- DONE:
  - Lasts exactly one cycle, with done=1.
  - result, rem and err update on the edge entering DONE: result=acc or q, rem=0 (multiply) or r (divide).
  - Next edge returns to IDLE, done goes to 0, and result, rem and err hold until the next DONE.
- Latency:
  - Normal operation: done is high in the cycle after E16, i.e. 16 cycles after start is accepted.
  - Divide-by-zero: done is high in the cycle after E0.
- Arithmetic unit drive:
  - IDLE and DONE: au_x=0, au_y=0, op=00.
  - The op=01 and op=11 codes are never issued.
- No combinational path from start, a or b to any output.

Test Plan:
- Multiply: start, div=0, a=300, b=7 -> busy for 17 cycles; done at cycle 16 after accept; result=0x0834, rem=0, err=0.
- Multiply wrap: a=0x1234, b=0x0100 -> result=0x3400. Also a=0xFFFF, b=0xFFFF -> result=0x0001.
- Divide: a=1000, b=7 -> result=142, rem=6, err=0. Also a=5, b=9 -> result=0, rem=5.
- Divide 17th-bit path: a=0xFFFF, b=0x8001 -> result=1, rem=0x7FFE. Also a=0xFFFF, b=1 -> result=0xFFFF, rem=0.
- Divide by zero: a=0x1234, b=0 -> done in the cycle after accept; result=0xFFFF, rem=0x1234, err=1. The next normal divide clears err.
- Control:
  - Pulse start with different operands during RUN and during DONE -> ignored; the first result is unchanged.
  - Assert rst at iteration 8 -> next cycle busy=0, done=0, result=0; no done pulse follows.
  - Back-to-back starts: start held high -> a new operation is accepted in the first IDLE cycle after DONE.
